ycbcr2rgb: RTL and testbench
============================

# ycbcr2rgb

Pipelined YCbCr-to-RGB565 converter for the license-plate image path. It takes 8-bit Y/Cb/Cr pixels with their frame sync and data-enable signals, and produces RGB565 pixels with those signals delayed by 3 clocks. Its job is to rebuild a displayable RGB565 stream (for example, for LCD/HDMI overlay) after processing in the YCbCr domain.

## Interface
Parameters:
- None. Coefficients and latency are fixed.

Ports:
- clk  in  1  pixel clock; all registers are rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- pre_frame_vsync  in  1  input frame sync.
- pre_frame_hsync  in  1  input line sync.
- pre_frame_de  in  1  input data enable.
- img_y  in  8  luma, unsigned.
- img_cb  in  8  blue-difference chroma, offset-128.
- img_cr  in  8  red-difference chroma, offset-128.
- post_frame_vsync  out  1  pre_frame_vsync delayed 3 clocks.
- post_frame_hsync  out  1  pre_frame_hsync delayed 3 clocks.
- post_frame_de  out  1  pre_frame_de delayed 3 clocks.
- img_red  out  5  R8[7:3].
- img_green  out  6  G8[7:2].
- img_blue  out  5  B8[7:3].

## Operation
- Integer equations, with cb_s = Cb − 128 and cr_s = Cr − 128 as 9-bit signed values:
  - R = (256·Y + 359·cr_s) >>> 8
  - G = (256·Y − 88·cb_s − 183·cr_s) >>> 8
  - B = (256·Y + 454·cb_s) >>> 8
- Stage 1 (registered):
  - y_s = {Y, 8'd0} as an 18-bit signed value.
  - Register the four signed products 359·cr_s, 88·cb_s, 183·cr_s, 454·cb_s, each 18-bit signed (|product| ≤ 58112).
- Stage 2 (registered): three 18-bit signed sums.
  - Sum ranges: R ∈ [−45952, 110873], G ∈ [−34417, 99968], B ∈ [−58112, 122938]. 18 bits cannot overflow.
- Stage 3 (registered): saturate each sum to an 8-bit value C8, then truncate to 565.
  - If sum[17] = 1 (negative): C8 = 0.
  - Else if sum[16:8] > 255: C8 = 255.
  - Else: C8 = sum[15:8]. This is floor rounding with no rounding constant.
  - Output img_red = R8[7:3], img_green = G8[7:2], img_blue = B8[7:3].
- Output gating: when post_frame_hsync = 0, img_red, img_green and img_blue are forced to 0. This matches the forward converter's convention.
- The pipeline runs every clock and is not stalled by de. Data presented while de = 0 still propagates but is not meaningful.

## Timing
- Latency is exactly 3 clocks, input to output, for both data and sync signals.
- Throughput is one pixel per clock. There is no back-pressure.
- The three sync signals pass through 3-bit shift registers and are never modified.
- Reset values: every output and every internal register is 0 while rst_n = 0.
  - Assertion takes effect immediately (asynchronous), including in the middle of a line.
- After rst_n deasserts, the first valid output appears on the 3rd rising edge.
  - The first 2 output cycles show syncs = 0 and RGB = 0.
- Back-to-back pixels with different values must come out on consecutive cycles with no cross-contamination between pipeline stages.

## Test plan
- Reset: assert rst_n = 0 mid-stream with hsync = 1 -> all outputs 0 immediately (asynchronous); on release, outputs stay 0 for 2 clocks.
- Mid-grey: Y = 128, Cb = 128, Cr = 128, hsync = 1 -> 3 clocks later R = 16, G = 32, B = 16.
- Overflow clamp: Y = 255, Cb = 128, Cr = 255 -> R = 31 (clamped), G = 41, B = 31.
- Underflow clamp: Y = 0, Cb = 0, Cr = 0 -> R = 0, G = 33, B = 0 (R and B clamped from negative).
- Saturated red: Y = 81, Cb = 90, Cr = 240 -> R = 29, G = 3, B = 1.
- Sync alignment and gating:
  - Random vsync/hsync/de pattern with random pixels -> each sync output equals its input delayed 3 clocks.
  - RGB = 0 whenever post_frame_hsync = 0.
  - When hsync = 1, RGB matches a bit-exact reference model of the equations above.

Source files
------------

// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: three-stage pipelined YCbCr (8-bit) to RGB565 converter.
// Stage 1 forms the scaled luma and the four chroma products, stage 2 adds
// them into one 18-bit sum per colour, and stage 3 saturates each sum to
// 8 bits and keeps the top 5/6/5 bits. The frame syncs ride alongside in
// 3-deep shift registers so data and syncs leave together.
module ycbcr2rgb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_hsync,
    input  logic       pre_frame_de,
    input  logic [7:0] img_y,
    input  logic [7:0] img_cb,
    input  logic [7:0] img_cr,
    output logic       post_frame_vsync,
    output logic       post_frame_hsync,
    output logic       post_frame_de,
    output logic [4:0] img_red,
    output logic [5:0] img_green,
    output logic [4:0] img_blue
);

    // Stage 1 registers: scaled luma and the chroma products
    logic signed [17:0] y_s_d,    y_s_q;
    logic signed [17:0] cr359_d,  cr359_q;
    logic signed [17:0] cb88_d,   cb88_q;
    logic signed [17:0] cr183_d,  cr183_q;
    logic signed [17:0] cb454_d,  cb454_q;

    // Stage 2 registers: per-colour sums
    logic signed [17:0] r_sum_d,  r_sum_q;
    logic signed [17:0] g_sum_d,  g_sum_q;
    logic signed [17:0] b_sum_d,  b_sum_q;

    // Stage 3 registers: truncated 565 colour fields
    logic [4:0] red_d,   red_q;
    logic [5:0] green_d, green_q;
    logic [4:0] blue_d,  blue_q;

    // Sync delay lines, bit 2 is the output tap
    logic [2:0] vsync_d, vsync_q;
    logic [2:0] hsync_d, hsync_q;
    logic [2:0] de_d,    de_q;

    // Intermediate combinational values
    logic signed [8:0]  cb_s;
    logic signed [8:0]  cr_s;
    logic signed [17:0] cb_ext;
    logic signed [17:0] cr_ext;
    logic [7:0]         red8;
    logic [7:0]         green8;
    logic [7:0]         blue8;

    // The low byte of each sum is the fraction dropped by the >>> 8, and the
    // low bits of each 8-bit colour are dropped by the 565 packing.
    logic unused_bits;
    assign unused_bits = ^{r_sum_q[7:0], g_sum_q[7:0], b_sum_q[7:0],
                           red8[2:0], green8[1:0], blue8[2:0]};

    // Stage 1: remove the chroma offset and form the fixed-coefficient products
    always_comb begin
        cb_s    = $signed({1'b0, img_cb}) - 9'sd128;
        cr_s    = $signed({1'b0, img_cr}) - 9'sd128;
        cb_ext  = $signed({{9{cb_s[8]}}, cb_s});
        cr_ext  = $signed({{9{cr_s[8]}}, cr_s});
        y_s_d   = $signed({2'b00, img_y, 8'd0});
        cr359_d = 18'sd359 * cr_ext;
        cb88_d  = 18'sd88  * cb_ext;
        cr183_d = 18'sd183 * cr_ext;
        cb454_d = 18'sd454 * cb_ext;
    end

    // Stage 2: combine luma and chroma terms; 18 bits covers every input
    always_comb begin
        r_sum_d = y_s_q + cr359_q;
        g_sum_d = y_s_q - cb88_q - cr183_q;
        b_sum_d = y_s_q + cb454_q;
    end

    // Stage 3: clamp each sum to 0..255 (floor of sum/256) then pack to 565
    always_comb begin
        if (r_sum_q[17])      red8 = 8'd0;
        else if (r_sum_q[16]) red8 = 8'hff;
        else                  red8 = r_sum_q[15:8];

        if (g_sum_q[17])      green8 = 8'd0;
        else if (g_sum_q[16]) green8 = 8'hff;
        else                  green8 = g_sum_q[15:8];

        if (b_sum_q[17])      blue8 = 8'd0;
        else if (b_sum_q[16]) blue8 = 8'hff;
        else                  blue8 = b_sum_q[15:8];

        red_d   = red8[7:3];
        green_d = green8[7:2];
        blue_d  = blue8[7:3];
    end

    // Sync shift registers advance every clock, independent of de
    always_comb begin
        vsync_d = {vsync_q[1:0], pre_frame_vsync};
        hsync_d = {hsync_q[1:0], pre_frame_hsync};
        de_d    = {de_q[1:0],    pre_frame_de};
    end

    // All pipeline state, cleared immediately when rst_n falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_s_q   <= '0;
            cr359_q <= '0;
            cb88_q  <= '0;
            cr183_q <= '0;
            cb454_q <= '0;
            r_sum_q <= '0;
            g_sum_q <= '0;
            b_sum_q <= '0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            vsync_q <= '0;
            hsync_q <= '0;
            de_q    <= '0;
        end else begin
            y_s_q   <= y_s_d;
            cr359_q <= cr359_d;
            cb88_q  <= cb88_d;
            cr183_q <= cr183_d;
            cb454_q <= cb454_d;
            r_sum_q <= r_sum_d;
            g_sum_q <= g_sum_d;
            b_sum_q <= b_sum_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            vsync_q <= vsync_d;
            hsync_q <= hsync_d;
            de_q    <= de_d;
        end
    end

    // Outputs: colour is blanked outside the active line (delayed hsync low)
    assign post_frame_vsync = vsync_q[2];
    assign post_frame_hsync = hsync_q[2];
    assign post_frame_de    = de_q[2];
    assign img_red          = hsync_q[2] ? red_q   : 5'd0;
    assign img_green        = hsync_q[2] ? green_q : 6'd0;
    assign img_blue         = hsync_q[2] ? blue_q  : 5'd0;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb_ycbcr2rgb: directed vector table, reset sequences and a random sync/pixel
// stream compared against an integer model of the colour equations.
module tb_ycbcr2rgb;

    logic       clk;
    logic       rst_n;
    logic       pre_frame_vsync;
    logic       pre_frame_hsync;
    logic       pre_frame_de;
    logic [7:0] img_y;
    logic [7:0] img_cb;
    logic [7:0] img_cr;
    logic       post_frame_vsync;
    logic       post_frame_hsync;
    logic       post_frame_de;
    logic [4:0] img_red;
    logic [5:0] img_green;
    logic [4:0] img_blue;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic       hs;
        int         r;
        int         g;
        int         b;
    } vec_t;

    typedef struct {
        logic       vs;
        logic       hs;
        logic       de;
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
    } pix_t;

    vec_t vecs[7];
    pix_t stim[64];

    ycbcr2rgb dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_hsync  (pre_frame_hsync),
        .pre_frame_de     (pre_frame_de),
        .img_y            (img_y),
        .img_cb           (img_cb),
        .img_cr           (img_cr),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_hsync (post_frame_hsync),
        .post_frame_de    (post_frame_de),
        .img_red          (img_red),
        .img_green        (img_green),
        .img_blue         (img_blue)
    );

    // 100 MHz pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one pixel with its sync flags
    task automatic applyStimulus(input logic vs, input logic hs, input logic de,
                                 input logic [7:0] y, input logic [7:0] cb,
                                 input logic [7:0] cr);
        pre_frame_vsync = vs;
        pre_frame_hsync = hs;
        pre_frame_de    = de;
        img_y           = y;
        img_cb          = cb;
        img_cr          = cr;
    endtask

    // Compare one observed value against the required value
    task automatic checkOutput(input string what, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", what, act, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Reference colour model: floor((256Y + k*c)/256) clamped, then packed
    function automatic int model_rgb(input logic [7:0] y, input logic [7:0] cb,
                                     input logic [7:0] cr);
        int yi, cbi, cri, r8, g8, b8;
        yi  = int'(y);
        cbi = int'(cb) - 128;
        cri = int'(cr) - 128;
        r8  = clamp8((256 * yi + 359 * cri) >>> 8);
        g8  = clamp8((256 * yi - 88 * cbi - 183 * cri) >>> 8);
        b8  = clamp8((256 * yi + 454 * cbi) >>> 8);
        return ((r8 / 8) * 2048) + ((g8 / 4) * 32) + (b8 / 8);
    endfunction

    function automatic int all_outputs();
        return int'({post_frame_vsync, post_frame_hsync, post_frame_de,
                     img_red, img_green, img_blue});
    endfunction

    initial begin
        int exp_rgb;
        int exp_sync;
        checks   = 0;
        failures = 0;

        // Hand-computed vectors: {Y, Cb, Cr, hsync, R5, G6, B5}
        vecs[0] = '{8'd128, 8'd128, 8'd128, 1'b1, 16, 32, 16};  // mid-grey
        vecs[1] = '{8'd255, 8'd128, 8'd255, 1'b1, 31, 41, 31};  // red overflow
        vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b1,  0, 33,  0};  // underflow
        vecs[3] = '{8'd81,  8'd90,  8'd240, 1'b1, 29,  3,  1};  // saturated red
        vecs[4] = '{8'd128, 8'd128, 8'd128, 1'b0,  0,  0,  0};  // blanked
        vecs[5] = '{8'd255, 8'd128, 8'd128, 1'b1, 31, 63, 31};  // white
        vecs[6] = '{8'd0,   8'd128, 8'd128, 1'b1,  0,  0,  0};  // black

        // Power-on reset: everything held at zero
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd200, 8'd50, 8'd60);
        tick();
        tick();
        checkOutput("reset_state", all_outputs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: hold each pixel and look 3 clocks later
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, vecs[i].hs, 1'b1, vecs[i].y, vecs[i].cb, vecs[i].cr);
            tick();
            tick();
            tick();
            checkOutput($sformatf("vec%0d_red", i),   int'(img_red),   vecs[i].r);
            checkOutput($sformatf("vec%0d_green", i), int'(img_green), vecs[i].g);
            checkOutput($sformatf("vec%0d_blue", i),  int'(img_blue),  vecs[i].b);
            checkOutput($sformatf("vec%0d_hsync", i), int'(post_frame_hsync), int'(vecs[i].hs));
        end

        // Latency: a new pixel must not appear before the third edge
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd0, 8'd128, 8'd128);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd255, 8'd128, 8'd128);
        tick();
        tick();
        checkOutput("latency_2clk_old", int'(img_red), 0);
        tick();
        checkOutput("latency_3clk_new", int'(img_red), 31);

        // Asynchronous reset in the middle of an active line
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128);
        tick();
        tick();
        tick();
        tick();
        checkOutput("pre_reset_red", int'(img_red), 16);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_clear", all_outputs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("post_reset_clk1", all_outputs(), 0);
        tick();
        checkOutput("post_reset_clk2", all_outputs(), 0);
        tick();
        checkOutput("post_reset_clk3_red", int'(img_red), 16);
        checkOutput("post_reset_clk3_sync",
                    int'({post_frame_vsync, post_frame_hsync, post_frame_de}), 7);

        // Random back-to-back stream with random syncs
        for (int i = 0; i < 64; i++) begin
            stim[i].vs = 1'($urandom_range(0, 1));
            stim[i].hs = 1'($urandom_range(0, 1));
            stim[i].de = 1'($urandom_range(0, 1));
            stim[i].y  = 8'($urandom_range(0, 255));
            stim[i].cb = 8'($urandom_range(0, 255));
            stim[i].cr = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < 67; i++) begin
            if (i >= 3) begin
                exp_sync = int'({stim[i-3].vs, stim[i-3].hs, stim[i-3].de});
                exp_rgb  = stim[i-3].hs ? model_rgb(stim[i-3].y, stim[i-3].cb, stim[i-3].cr) : 0;
                checkOutput($sformatf("stream%0d_sync", i - 3),
                            int'({post_frame_vsync, post_frame_hsync, post_frame_de}), exp_sync);
                checkOutput($sformatf("stream%0d_rgb", i - 3),
                            int'({img_red, img_green, img_blue}), exp_rgb);
            end
            if (i < 64)
                applyStimulus(stim[i].vs, stim[i].hs, stim[i].de,
                              stim[i].y, stim[i].cb, stim[i].cr);
            else
                applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
